// File: rtl/bin2bcd_16.sv
// bin2bcd_16: sequential 16-bit binary to 5-digit packed BCD converter.
// Uses shift-and-add-3 (double dabble), one bit per clock, 16 clocks per result.
// Its start/done handshake matches the upstream divider, so the divider's done
// can drive init_in directly.
// Optional feature macro: BIN2BCD_SIGNED_EN. When defined, BIN is treated as
// two's complement, the magnitude is converted and SIGN reports the sign.
// When undefined, BIN is unsigned and SIGN is tied to 0.
module bin2bcd_16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_in,
  input  logic [15:0] BIN,
  output logic [19:0] BCD,
  output logic        SIGN,
  output logic        busy,
  output logic        done
);

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [35:0] r_scratch;
  logic [35:0] w_corr;
  logic [35:0] w_shifted;
  logic [4:0]  r_count;
  logic [15:0] w_operand;
  logic        w_accept;
  logic        w_last;

  // A request is only honoured in IDLE; the last iteration is the 1 -> 0 count step.
  assign w_accept = (r_state == IDLE) && init_in;
  assign w_last   = (r_state == CONV) && (r_count == 5'd1);

`ifdef BIN2BCD_SIGNED_EN
  logic w_neg;
  logic r_sign_lat;

  // Convert the magnitude; 16'h8000 negates to itself, which reads as 32768 unsigned.
  assign w_neg     = BIN[15];
  assign w_operand = w_neg ? (~BIN + 16'd1) : BIN;

  // Latch the sign at accept and publish it together with the result digits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sign_lat <= 1'b0;
      SIGN       <= 1'b0;
    end else begin
      if (w_accept)
        r_sign_lat <= w_neg;
      if (w_last)
        SIGN <= r_sign_lat;
    end
  end
`else
  assign w_operand = BIN;
  assign SIGN      = 1'b0;
`endif

  // Add 3 to every BCD digit that is 5 or more, all digits in parallel, then shift.
  always_comb begin
    w_corr = r_scratch;
    for (int i = 0; i < 5; i++) begin
      if (r_scratch[16 + 4*i +: 4] >= 4'd5)
        w_corr[16 + 4*i +: 4] = r_scratch[16 + 4*i +: 4] + 4'd3;
    end
    w_shifted = {w_corr[34:0], 1'b0};
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_next_state;
  end

  // Next-state logic: accept in IDLE, return to IDLE after the 16th iteration.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (init_in) w_next_state = CONV;
      CONV: if (r_count == 5'd1) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath: load on accept, iterate in CONV, publish the result on the last step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scratch <= 36'h0;
      r_count   <= 5'd0;
      BCD       <= 20'h0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (w_accept) begin
        r_scratch <= {20'h0, w_operand};
        r_count   <= 5'd16;
        busy      <= 1'b1;
      end else if (r_state == CONV) begin
        r_scratch <= w_shifted;
        r_count   <= r_count - 5'd1;
        if (w_last) begin
          BCD  <= w_shifted[35:16];
          done <= 1'b1;
          busy <= 1'b0;
        end
      end
    end
  end

endmodule
